// File: rtl/gate_exerciser_pkg.sv
// ============================================================================
// Module   : gate_exerciser_pkg
// Desc     : Shared types and truth-table constants for the gate exerciser.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gate_exerciser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 4;

    // Bit i is the gate output expected for {in1,in0} == i.
    localparam logic [NUM_VECTORS-1:0] TT_AND = 4'b1000;
    localparam logic [NUM_VECTORS-1:0] TT_OR  = 4'b1110;
    localparam logic [NUM_VECTORS-1:0] TT_XOR = 4'b0110;

endpackage

`default_nettype wire

// File: rtl/gate_exerciser_if.sv
// ============================================================================
// Module   : gate_exerciser_if
// Desc     : Control, gate-pin and result signals of the gate exerciser.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface gate_exerciser_if;

    logic                                    start;
    logic                                    gate_out;
    logic                                    drv0;
    logic                                    drv1;
    logic                                    busy;
    logic                                    done;
    logic                                    pass;
    logic [gate_exerciser_pkg::NUM_VECTORS-1:0] fail_vec;

    modport master (
        input  start,
        input  gate_out,
        output drv0,
        output drv1,
        output busy,
        output done,
        output pass,
        output fail_vec
    );

    modport slave (
        output start,
        output gate_out,
        input  drv0,
        input  drv1,
        input  busy,
        input  done,
        input  pass,
        input  fail_vec
    );

endinterface

`default_nettype wire

// File: rtl/gate_exerciser_sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Desc     : 1-bit two-flop synchronizer for asynchronous board pins.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic d,
    output logic      q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/gate_exerciser.sv
// ============================================================================
// Module   : gate_exerciser
// Desc     : Sweeps a two-input gate through all vectors and checks its output.
//            GATE_EXERCISER_LOOP_EN selects continuous back-to-back sweeps.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gate_exerciser
    import gate_exerciser_pkg::*;
#(
    parameter int                      SETTLE_CYCLES = 4,
    parameter logic [NUM_VECTORS-1:0]  EXPECT        = TT_AND
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    gate_exerciser_if.master  gx
);

    localparam int                 CNT_W      = $clog2(SETTLE_CYCLES);
    localparam int                 IDX_W      = $clog2(NUM_VECTORS);
    localparam logic [CNT_W-1:0]   c_CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0]   c_IDX_LAST = IDX_W'(NUM_VECTORS - 1);
`ifdef GATE_EXERCISER_LOOP_EN
    localparam state_t             c_WRAP_ST  = ST_SETTLE;
`else
    localparam state_t             c_WRAP_ST  = ST_DONE;
`endif

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [NUM_VECTORS-1:0]   fail_vec_q, fail_vec_d;
    logic                     gate_sync;
`ifdef GATE_EXERCISER_LOOP_EN
    logic                     swept_q, swept_d;
`endif

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gx.gate_out),
        .q     (gate_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_vec_q <= '0;
`ifdef GATE_EXERCISER_LOOP_EN
            swept_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_vec_q <= fail_vec_d;
`ifdef GATE_EXERCISER_LOOP_EN
            swept_q    <= swept_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (gx.start) state_d = ST_SETTLE;
            ST_SETTLE:        if (cnt_q == c_CNT_LAST) state_d = ST_SAMPLE;
            ST_SAMPLE:        state_d = (idx_q == c_IDX_LAST) ? c_WRAP_ST : ST_SETTLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = done_q;
        fail_vec_d = fail_vec_q;
`ifdef GATE_EXERCISER_LOOP_EN
        swept_d    = swept_q;
        done_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (gx.start) begin
                    idx_d  = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    done_d = 1'b0;
`ifndef GATE_EXERCISER_LOOP_EN
                    fail_vec_d = '0;
`endif
                end
            end
            ST_SETTLE: cnt_d = cnt_q + 1'b1;
            ST_SAMPLE: begin
                if (gate_sync != EXPECT[idx_q]) fail_vec_d[idx_q] = 1'b1;
                cnt_d = '0;
                if (idx_q == c_IDX_LAST) begin
                    done_d = 1'b1;
`ifdef GATE_EXERCISER_LOOP_EN
                    swept_d = 1'b1;
                    idx_d   = '0;
`else
                    busy_d  = 1'b0;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // The drive pins are the vector index itself, so they hold 3 after a sweep.
    assign gx.drv0     = idx_q[0];
    assign gx.drv1     = idx_q[1];
    assign gx.busy     = busy_q;
    assign gx.done     = done_q;
    assign gx.fail_vec = fail_vec_q;
`ifdef GATE_EXERCISER_LOOP_EN
    assign gx.pass     = swept_q && (fail_vec_q == '0);
`else
    assign gx.pass     = done_q && (fail_vec_q == '0);
`endif

endmodule

`default_nettype wire

// File: doc/gate_exerciser.md
Name: gate_exerciser

Overview:
- On-board self-test driver for the two-input gate blocks on the FPGA.
- Drives the gate's two inputs through all four vectors and samples the gate's output through a synchronizer.
- Compares each sample against a parameterised truth table and reports pass/fail per vector.
- Sits on the opposite side of the gate pins: its outputs feed the gate inputs, and its input takes the gate output.

Parameters:
SETTLE_CYCLES, 4, cycles each vector is held before sampling; legal minimum 3 (covers 2-flop sync plus 1 cycle of margin)
EXPECT, 4'b1000, expected gate output per vector; bit i is the expected value when {drv1,drv0}=i (default = AND)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a sweep; accepted only in IDLE or DONE
gate_out  input  1  output of gate under test (asynchronous to clk, synchronized internally)
drv0  output  1  gate input 0, registered
drv1  output  1  gate input 1, registered
busy  output  1  high while a sweep is in progress
done  output  1  high in DONE state (level) until the next accepted start
pass  output  1  done && fail_vec==0
fail_vec  output  4  bit i set if vector i mismatched in the last sweep

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, drv0=drv1=0, busy=0, done=0, pass=0, fail_vec=0, idx=0, cnt=0, sync flops=0.
- States: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered or decoded from registers; no combinational path from gate_out to any output.
- IDLE or DONE, start=1:
  - idx<=0, {drv1,drv0}<=0, cnt<=0, fail_vec<=0.
  - done<=0, busy<=1, go to SETTLE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (1 cycle):
  - If gate_sync != EXPECT[idx], set fail_vec[idx].
  - If idx==3: go to DONE, busy<=0, done<=1.
  - Otherwise: idx<=idx+1, {drv1,drv0}<=idx+1, cnt<=0, go to SETTLE.
- Latency: each vector occupies SETTLE_CYCLES+1 cycles. done rises 4*(SETTLE_CYCLES+1) cycles after the start-accept edge (20 cycles at the default).
- Drive outputs hold their last vector (3, i.e. both high) in DONE and return to 0 only on a new start or reset.
- start while busy is ignored; no queuing.
- start in DONE clears done, pass and fail_vec on the accept edge.
- gate_sync is gate_out after a 2-flop synchronizer. gate_out is assumed stable within SETTLE_CYCLES-2 cycles of a drive change.
- rst_n assertion mid-sweep immediately returns everything to reset values. The sweep is abandoned and not resumed.
- cnt width is clog2(SETTLE_CYCLES); idx is 2 bits and never wraps outside LOOP_EN.

Optional Feature:
GATE_EXERCISER_LOOP_EN
- Defined:
  - After SAMPLE of idx==3, idx<=0, drive<=0 and go to SETTLE; DONE is never entered.
  - busy stays 1 after the first start.
  - done becomes a 1-cycle pulse per completed sweep.
  - fail_vec bits are sticky across sweeps and cleared only by rst_n; start is ignored once running.
  - pass is a level: at least one sweep completed and fail_vec==0.
- Undefined: single-sweep behaviour exactly as above.

Decomposition:
- Shared package: state enum (IDLE, SETTLE, SAMPLE, DONE), NUM_VECTORS=4, AND/OR/XOR truth-table constants (4'b1000, 4'b1110, 4'b0110) for EXPECT.
- One sub-module: sync_2ff (1-bit two-flop synchronizer, clk, rst_n, d, q). It is reused by any block sampling board pins.

Test Plan:
- AND model on drv→gate_out, SETTLE_CYCLES=4, start pulse → drive sequence 00,01,10,11 each held 5 cycles; done=1 at cycle 20 after accept; fail_vec=0000, pass=1.
- gate_out stuck at 0 → fail_vec=1000, pass=0, done=1.
- gate_out stuck at 1 → fail_vec=0111, pass=0.
- start pulsed again at cycle 7 mid-sweep → ignored; sweep completes at cycle 20 unchanged. Then start in DONE → done/fail_vec clear on the next edge and the sweep reruns.
- rst_n low at cycle 9 (vector 1) → drv=00, busy=0, fail_vec=0 immediately; no done; a subsequent start runs a full clean sweep.
- LOOP_EN, EXPECT=OR, stuck-at-0 gate for sweep 2 only → done pulses at cycles 20, 40, 60; fail_vec=1110 after sweep 2 and remains 1110 through sweep 3; pass=0.
